vga_layer_arbiter: RTL and testbench

Shares the single 8-bit VGA colour output (rrrgggbb) among NUM_LAYERS drawing requesters: score overlay, playfield, sprites and similar. Each requester flags pixel ownership per clock. The block selects the winner by programmable priority and applies per-layer enable and blink. Configuration is written through a valid/ready port into shadow registers and committed only at frame boundaries, so the picture never tears. The block sits between the vga_sync-driven renderers and the board RGB/sync pins.

---
 rtl/vga_layer_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_vga_layer_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_arbiter.sv
// vga_layer_arbiter
// Purpose: picks which of NUM_LAYERS renderers drives the shared rrrgggbb
// colour output on each pixel. The pick uses a programmable priority, per-layer
// enable and per-layer blink. Configuration goes into shadow registers and is
// copied to the active set on frame_tick, so a frame never shows a mix of old
// and new settings.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   frame_tick            one-clock pulse at start of vertical blanking (commit + blink step)
//   video_on, hsync_in, vsync_in   timing from vga_sync
//   layer_req[i]          layer i owns the current pixel
//   layer_rgb             layer i colour at [i*COLOR_W +: COLOR_W]
//   cfg_*                 configuration write port (see handshake note below)
//   rgb, hsync, vsync     colour and syncs, 2 clocks after the inputs
//   win_layer, collision  winning layer index / multiple-visible flag, aligned with rgb
//
// Handshake: a config write transfers on a clk edge where cfg_valid && cfg_ready.
// cfg_ready is low only on the frame_tick cycle so a write can never race the
// shadow->active commit; the writer holds cfg_valid and its payload until a
// transfer happens.
module vga_layer_arbiter #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          video_on,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [NUM_LAYERS-1:0]         layer_req,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [1:0]                    cfg_layer,
  input  logic                          cfg_enable,
  input  logic                          cfg_blink,
  input  logic [1:0]                    cfg_prio,
  input  logic                          cfg_bg_we,
  input  logic [COLOR_W-1:0]            cfg_bg_rgb,
  output logic [COLOR_W-1:0]            rgb,
  output logic                          hsync,
  output logic                          vsync,
  output logic [1:0]                    win_layer,
  output logic                          collision
);

  localparam int LW    = 2;
  localparam int CNT_W = $clog2(NUM_LAYERS + 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // Shadow (written by cfg port) and active (used for drawing) configuration
  logic                sh_en    [NUM_LAYERS];
  logic                sh_blink [NUM_LAYERS];
  logic [LW-1:0]       sh_prio  [NUM_LAYERS];
  logic [COLOR_W-1:0]  sh_bg;
  logic                act_en    [NUM_LAYERS];
  logic                act_blink [NUM_LAYERS];
  logic [LW-1:0]       act_prio  [NUM_LAYERS];
  logic [COLOR_W-1:0]  act_bg;

  logic [7:0]          blink_cnt;
  logic                blink_phase;

  // Stage 1 registers
  logic [NUM_LAYERS-1:0]         s1_vis;
  logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb;
  logic                          s1_video;
  logic                          s1_hs;
  logic                          s1_vs;

  logic [NUM_LAYERS-1:0] vis;
  logic                  cfg_fire;

  assign cfg_ready = !frame_tick;
  assign cfg_fire  = cfg_valid && cfg_ready;

  // Configuration: shadow writes and frame-boundary commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        sh_en[i]     <= 1'b1;
        sh_blink[i]  <= 1'b0;
        sh_prio[i]   <= LW'(i);
        act_en[i]    <= 1'b1;
        act_blink[i] <= 1'b0;
        act_prio[i]  <= LW'(i);
      end
      sh_bg  <= '0;
      act_bg <= '0;
    end else begin
      if (cfg_fire) begin
        if (cfg_bg_we) begin
          sh_bg <= cfg_bg_rgb;
        end else begin
          sh_en[cfg_layer]    <= cfg_enable;
          sh_blink[cfg_layer] <= cfg_blink;
          sh_prio[cfg_layer]  <= cfg_prio;
        end
      end
      // cfg_fire is never true here, so the copy sees a settled shadow set
      if (frame_tick) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          act_en[i]    <= sh_en[i];
          act_blink[i] <= sh_blink[i];
          act_prio[i]  <= sh_prio[i];
        end
        act_bg <= sh_bg;
      end
    end
  end

  // Blink timer: phase flips every BLINK_FRAMES frame ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  // Visible mask: blinking layers vanish while the phase is high
  always_comb begin
    vis = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      vis[i] = layer_req[i] && act_en[i] && !(act_blink[i] && blink_phase);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vis   <= '0;
      s1_rgb   <= '0;
      s1_video <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
    end else begin
      s1_vis   <= vis;
      s1_rgb   <= layer_rgb;
      s1_video <= video_on;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
    end
  end

  // Stage 2 select: strict '>' scanning upward keeps the lowest index on ties
  logic                found;
  logic [LW-1:0]       best_prio;
  logic [LW-1:0]       win_idx;
  logic [COLOR_W-1:0]  win_rgb;
  logic [CNT_W-1:0]    vis_cnt;

  always_comb begin
    found     = 1'b0;
    best_prio = '0;
    win_idx   = '0;
    win_rgb   = act_bg;
    vis_cnt   = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (s1_vis[i]) begin
        vis_cnt = vis_cnt + CNT_W'(1);
        if (!found || (act_prio[i] > best_prio)) begin
          found     = 1'b1;
          best_prio = act_prio[i];
          win_idx   = LW'(i);
          win_rgb   = s1_rgb[i*COLOR_W +: COLOR_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= '0;
      win_layer <= '0;
      collision <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
    end else begin
      hsync <= s1_hs;
      vsync <= s1_vs;
      if (!s1_video) begin
        rgb       <= '0;
        win_layer <= '0;
        collision <= 1'b0;
      end else begin
        rgb       <= win_rgb;
        win_layer <= win_idx;
        collision <= (vis_cnt >= CNT_W'(2));
      end
    end
  end

endmodule

// File: tb/tb_vga_layer_arbiter.sv
module tb_vga_layer_arbiter;
  localparam int NL = 4;
  localparam int CW = 8;
  localparam int BF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          frame_tick = 1'b0, video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [NL-1:0] layer_req = '0;
  logic [NL*CW-1:0] layer_rgb = '0;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [1:0]    cfg_layer = '0, cfg_prio = '0;
  logic          cfg_enable = 1'b0, cfg_blink = 1'b0, cfg_bg_we = 1'b0;
  logic [CW-1:0] cfg_bg_rgb = '0;
  logic [CW-1:0] rgb;
  logic          hsync, vsync, collision;
  logic [1:0]    win_layer;

  vga_layer_arbiter #(.NUM_LAYERS(NL), .COLOR_W(CW), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_req(layer_req), .layer_rgb(layer_rgb),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_enable(cfg_enable), .cfg_blink(cfg_blink), .cfg_prio(cfg_prio),
    .cfg_bg_we(cfg_bg_we), .cfg_bg_rgb(cfg_bg_rgb), .rgb(rgb), .hsync(hsync),
    .vsync(vsync), .win_layer(win_layer), .collision(collision)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CW-1:0] rgb;
    logic [1:0]    win;
    logic          coll;
    logic          hs;
    logic          vs;
  } out_t;

  out_t exp_q[$];

  logic          m_sh_en [NL], m_sh_bl [NL], m_act_en [NL], m_act_bl [NL];
  logic [1:0]    m_sh_pr [NL], m_act_pr [NL];
  logic [CW-1:0] m_sh_bg, m_act_bg;
  int            m_bcnt;
  logic          m_phase;
  // what the first pipeline stage holds
  logic [NL-1:0]    p_vis = '0;
  logic [NL*CW-1:0] p_rgb = '0;
  logic             p_vid = 1'b0, p_hs = 1'b0, p_vs = 1'b0;

  task automatic model_defaults();
    for (int i = 0; i < NL; i++) begin
      m_sh_en[i] = 1'b1; m_sh_bl[i] = 1'b0; m_sh_pr[i] = 2'(i);
      m_act_en[i] = 1'b1; m_act_bl[i] = 1'b0; m_act_pr[i] = 2'(i);
    end
    m_sh_bg = '0; m_act_bg = '0; m_bcnt = 0; m_phase = 1'b0;
  endtask

  // Winner = highest score where score ranks priority first, then lower index
  function automatic out_t arbitrate(input logic [NL-1:0] v, input logic [NL*CW-1:0] c);
    out_t o;
    int best, bscore, score;
    best = -1; bscore = -1;
    for (int i = 0; i < NL; i++) begin
      score = int'(m_act_pr[i]) * NL + (NL - 1 - i);
      if (v[i] && score > bscore) begin bscore = score; best = i; end
    end
    o = '0;
    o.coll = ($countones(v) >= 2);
    if (best < 0) o.rgb = m_act_bg;
    else begin o.rgb = c[best*CW +: CW]; o.win = 2'(best); end
    return o;
  endfunction

  // One clock: predict, advance the model, let the edge happen, compare
  task automatic cycle();
    out_t e;
    #1;
    chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, !frame_tick});
    if (reset) e = '0;
    else if (!p_vid) begin e = '0; e.hs = p_hs; e.vs = p_vs; end
    else begin e = arbitrate(p_vis, p_rgb); e.hs = p_hs; e.vs = p_vs; end
    exp_q.push_back(e);
    if (reset) begin
      p_vis = '0; p_rgb = '0; p_vid = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
      model_defaults();
    end else begin
      for (int i = 0; i < NL; i++)
        p_vis[i] = layer_req[i] & m_act_en[i] & ~(m_act_bl[i] & m_phase);
      p_rgb = layer_rgb; p_vid = video_on; p_hs = hsync_in; p_vs = vsync_in;
      if (cfg_valid && !frame_tick) begin
        if (cfg_bg_we) m_sh_bg = cfg_bg_rgb;
        else begin
          m_sh_en[cfg_layer] = cfg_enable; m_sh_bl[cfg_layer] = cfg_blink;
          m_sh_pr[cfg_layer] = cfg_prio;
        end
      end
      if (frame_tick) begin
        m_act_en = m_sh_en; m_act_bl = m_sh_bl; m_act_pr = m_sh_pr; m_act_bg = m_sh_bg;
        if (m_bcnt == BF - 1) begin m_bcnt = 0; m_phase = !m_phase; end
        else m_bcnt++;
      end
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rgb", {24'b0, rgb}, {24'b0, e.rgb});
    chk("win_layer", {30'b0, win_layer}, {30'b0, e.win});
    chk("collision", {31'b0, collision}, {31'b0, e.coll});
    chk("hsync", {31'b0, hsync}, {31'b0, e.hs});
    chk("vsync", {31'b0, vsync}, {31'b0, e.vs});
    chk("blink_cnt", {24'b0, dut.blink_cnt}, 32'(m_bcnt));
    chk("blink_phase", {31'b0, dut.blink_phase}, {31'b0, m_phase});
  endtask

  // ---------------- drivers ----------------
  task automatic cfg_write(input logic [1:0] l, input logic en, input logic bl, input logic [1:0] pr);
    cfg_valid = 1'b1; cfg_bg_we = 1'b0; cfg_layer = l; cfg_enable = en; cfg_blink = bl; cfg_prio = pr;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic cfg_bg(input logic [CW-1:0] c);
    cfg_valid = 1'b1; cfg_bg_we = 1'b1; cfg_bg_rgb = c;
    cycle();
    cfg_valid = 1'b0; cfg_bg_we = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic set_px(input logic [NL-1:0] r, input logic [NL*CW-1:0] c);
    layer_req = r; layer_rgb = c; video_on = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [NL-1:0]    req;
    logic [NL*CW-1:0] colors;
    logic             vid;
    logic [CW-1:0]    exp_rgb;
    logic [1:0]       exp_win;
    logic             exp_coll;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{4'b0001, 32'h0000001D, 1'b1, 8'h1D, 2'd0, 1'b0};
    vecs[1] = '{4'b1010, 32'h0300E000, 1'b1, 8'h03, 2'd3, 1'b1};
    vecs[2] = '{4'b0000, 32'h44332211, 1'b1, 8'h00, 2'd0, 1'b0};
    vecs[3] = '{4'b1111, 32'h44332211, 1'b1, 8'h44, 2'd3, 1'b1};
    vecs[4] = '{4'b0110, 32'h44332211, 1'b1, 8'h33, 2'd2, 1'b1};
    vecs[5] = '{4'b1111, 32'h44332211, 1'b0, 8'h00, 2'd0, 1'b0};

    model_defaults();
    cycle(); cycle();
    reset = 1'b0;
    chk("reset_rgb", {24'b0, rgb}, 32'h0);

    // default configuration, table-driven
    for (int k = 0; k < 6; k++) begin
      layer_req = vecs[k].req; layer_rgb = vecs[k].colors; video_on = vecs[k].vid;
      cycle(); cycle();
      chk($sformatf("vec%0d_rgb", k), {24'b0, rgb}, {24'b0, vecs[k].exp_rgb});
      chk($sformatf("vec%0d_win", k), {30'b0, win_layer}, {30'b0, vecs[k].exp_win});
      chk($sformatf("vec%0d_coll", k), {31'b0, collision}, {31'b0, vecs[k].exp_coll});
    end

    // priority reprogram takes effect only after the tick
    set_px(4'b1010, 32'h0300E000);
    cfg_write(2'd1, 1'b1, 1'b0, 2'd3);
    cfg_write(2'd3, 1'b1, 1'b0, 2'd0);
    cycle(); cycle();
    chk("prio_pre_tick", {24'b0, rgb}, 32'h03);
    tick(); cycle(); cycle();
    chk("prio_post_rgb", {24'b0, rgb}, 32'hE0);
    chk("prio_post_win", {30'b0, win_layer}, 32'd1);
    do_reset();

    // shadow timing: disable L0 and set bg mid-frame
    set_px(4'b0001, 32'h0000001D);
    cfg_write(2'd0, 1'b0, 1'b0, 2'd0);
    cfg_bg(8'h92);
    cycle(); cycle();
    chk("shadow_hold", {24'b0, rgb}, 32'h1D);
    tick(); cycle(); cycle();
    chk("shadow_bg", {24'b0, rgb}, 32'h92);

    // write presented on the tick cycle is refused
    frame_tick = 1'b1; cfg_valid = 1'b1; cfg_bg_we = 1'b1; cfg_bg_rgb = 8'h55;
    #1;
    chk("ready_on_tick", {31'b0, cfg_ready}, 32'd0);
    cycle();
    frame_tick = 1'b0; cfg_valid = 1'b0; cfg_bg_we = 1'b0;
    tick(); cycle(); cycle();
    chk("tick_write_lost", {24'b0, rgb}, 32'h92);
    do_reset();

    // blink: phase after tick n is (n/2)%2
    set_px(4'b0001, 32'h0000001D);
    cfg_write(2'd0, 1'b1, 1'b1, 2'd0);
    for (int n = 1; n <= 8; n++) begin
      tick(); cycle(); cycle();
      chk($sformatf("blink_n%0d", n), {24'b0, rgb}, ((n / 2) % 2) ? 32'h00 : 32'h1D);
    end

    // blanking and sync alignment
    video_on = 1'b0; layer_req = 4'b1111; hsync_in = 1'b0;
    cycle(); cycle();
    chk("blank_rgb", {24'b0, rgb}, 32'h0);
    chk("blank_coll", {31'b0, collision}, 32'd0);
    hsync_in = 1'b1;
    cycle();
    chk("hsync_d1", {31'b0, hsync}, 32'd0);
    cycle();
    chk("hsync_d2", {31'b0, hsync}, 32'd1);
    hsync_in = 1'b0;

    // reset mid-operation with blink active and prio changed
    set_px(4'b1010, 32'h0300E000);
    cfg_write(2'd1, 1'b1, 1'b0, 2'd3);
    cfg_write(2'd3, 1'b1, 1'b1, 2'd0);
    tick(); tick(); cycle();
    cfg_write(2'd2, 1'b0, 1'b0, 2'd0);
    do_reset();
    chk("rst_rgb", {24'b0, rgb}, 32'h0);
    chk("rst_win", {30'b0, win_layer}, 32'd0);
    chk("rst_cnt", {24'b0, dut.blink_cnt}, 32'd0);
    cycle(); cycle();
    chk("rst_default_rgb", {24'b0, rgb}, 32'h03);
    chk("rst_default_win", {30'b0, win_layer}, 32'd3);

    // frame_tick during reset is ignored
    reset = 1'b1; frame_tick = 1'b1;
    cycle();
    reset = 1'b0; frame_tick = 1'b0;
    chk("tick_in_reset", {24'b0, dut.blink_cnt}, 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      layer_req  = 4'($urandom_range(0, 15));
      layer_rgb  = $urandom;
      video_on   = ($urandom_range(0, 7) != 0);
      hsync_in   = 1'($urandom_range(0, 1));
      vsync_in   = 1'($urandom_range(0, 1));
      frame_tick = ($urandom_range(0, 19) == 0);
      cfg_valid  = ($urandom_range(0, 5) == 0);
      cfg_bg_we  = ($urandom_range(0, 3) == 0);
      cfg_layer  = 2'($urandom_range(0, 3));
      cfg_enable = ($urandom_range(0, 3) != 0);
      cfg_blink  = 1'($urandom_range(0, 1));
      cfg_prio   = 2'($urandom_range(0, 3));
      cfg_bg_rgb = 8'($urandom_range(0, 255));
      reset      = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0; frame_tick = 1'b0; cfg_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
